// File: rtl/apb_pkg.sv
// Shared definitions for the N-slave APB4 bridge: FSM encoding, PPROT bits, default widths.
// The optional transfer timeout is enabled by defining APB_TIMEOUT_EN.
package apb_pkg;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_NUM_SLV = 4;
  localparam int APB_SEL_W   = 2;
`ifdef APB_TIMEOUT_EN
  localparam int APB_TIMEOUT_CYC = 16;
`endif

  localparam logic [2:0] PPROT_PRIV  = 3'b001;
  localparam logic [2:0] PPROT_NSEC  = 3'b010;
  localparam logic [2:0] PPROT_INSTR = 3'b100;
  localparam logic [2:0] PPROT_MASK  = PPROT_PRIV | PPROT_NSEC | PPROT_INSTR;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decoder: decode field -> one-hot select, plus error when the
// field addresses a slave that does not exist.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int SEL_W   = APB_SEL_W
) (
  input  logic [SEL_W-1:0]   i_idx,
  output logic [NUM_SLV-1:0] o_sel,
  output logic               o_decode_err
);

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (i_idx == SEL_W'(i)) o_sel[i] = 1'b1;
    end
    o_decode_err = ~|o_sel;
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// APB4 master bridge from a valid/ready request port to NUM_SLV slaves on a shared bus.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module apb_bridge_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int SEL_W   = APB_SEL_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
`endif
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [2:0]                PPROT,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA
);

  apb_state_e            r_state;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;
  logic [NUM_SLV-1:0]    r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_W-1:0]     r_paddr;
  logic [DATA_W-1:0]     r_pwdata;
  logic [DATA_W/8-1:0]   r_pstrb;
  logic [2:0]            r_pprot;
`ifdef APB_TIMEOUT_EN
  logic [7:0]            r_wait_cnt;
`endif

  logic [NUM_SLV-1:0]    w_sel;
  logic                  w_dec_err;
  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_W-1:0]     w_prdata;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .i_idx        (req_addr[ADDR_W-1 -: SEL_W]),
    .o_sel        (w_sel),
    .o_decode_err (w_dec_err)
  );

  // The registered one-hot select masks the return path, so idle slaves are ignored.
  assign w_pready  = |(PREADY  & r_psel);
  assign w_pslverr = |(PSLVERR & r_psel);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_psel[i]) w_prdata = w_prdata | PRDATA[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_ready) begin
            r_ready  <= 1'b0;
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_pstrb  <= req_write ? req_strb : '0;
            r_pprot  <= req_prot & PPROT_MASK;
            if (w_dec_err) begin
              r_state <= ST_DERR;
            end else begin
              r_psel  <= w_sel;
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          r_penable  <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_pslverr;
            // Read data is only returned for clean reads.
            r_rsp_rdata <= (!r_pwrite && !w_pslverr) ? w_prdata : '0;
            r_ready     <= 1'b1;
            r_state     <= ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_ready     <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        ST_DERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Self-checking bench for apb_bridge_nslv with three slaves (so one decode value is unmapped).
// Timeout scenario runs only when APB_TIMEOUT_EN is defined.
module tb_apb_bridge_nslv;
  import apb_pkg::*;

  localparam int NS = 3;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  logic           req_valid, req_ready, req_write;
  logic [31:0]    req_addr, req_wdata;
  logic [3:0]     req_strb;
  logic [2:0]     req_prot;
  logic           rsp_valid, rsp_err;
  logic [31:0]    rsp_rdata;
  logic [NS-1:0]  PSEL, PREADY, PSLVERR;
  logic           PENABLE, PWRITE;
  logic [31:0]    PADDR, PWDATA;
  logic [3:0]     PSTRB;
  logic [2:0]     PPROT;
  logic [NS*32-1:0] PRDATA;

  int          wait_cfg  [NS];
  logic        err_cfg   [NS];
  logic [31:0] rdata_cfg [NS];
  int          acc_cnt;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          pen;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  apb_bridge_nslv #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NS), .SEL_W(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Slave models; idle slaves drive ready/error high so a bridge that fails to mask them is caught.
  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    for (int i = 0; i < NS; i++) begin
      PREADY[i]  = PSEL[i] ? (PENABLE && (acc_cnt >= wait_cfg[i])) : 1'b1;
      PSLVERR[i] = PSEL[i] ? err_cfg[i] : 1'b1;
    end
  end
  assign PRDATA = {rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};

  always @(posedge PCLK) begin
    if (PENABLE && ((PSEL & ~PREADY) != '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic do_xfer(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         input logic [2:0] exp_psel, input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat, input int exp_pen);
    exp_t e;
    int   cyc, pen;
    bit   bad, done;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge PCLK); cyc++; end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{err: exp_err, rdata: exp_rdata, lat: exp_lat, pen: exp_pen});
    cyc = 0; pen = 0; bad = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge PCLK);
      cyc++;
      req_valid = 1'b0;
      if (cyc == 1) begin
        n_vec++;
        if (PSEL !== exp_psel || PENABLE !== 1'b0 || req_ready !== 1'b0) begin
          n_err++; $display("FAIL %s setup: PSEL=%b PENABLE=%b ready=%b required PSEL=%b PENABLE=0 ready=0",
                            name, PSEL, PENABLE, req_ready, exp_psel);
        end
      end
      if (PSEL != '0) begin
        if (PSEL !== exp_psel || PADDR !== addr || PWRITE !== wr || PPROT !== prot ||
            PSTRB !== (wr ? strb : 4'h0) || (wr && PWDATA !== wdata)) bad = 1;
        if (PENABLE) pen++;
      end
      if (rsp_valid) begin
        done = 1;
        e = sb.pop_front();
        n_vec++;
        if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
          n_err++; $display("FAIL %s rsp: err=%b rdata=%h required err=%b rdata=%h",
                            name, rsp_err, rsp_rdata, e.err, e.rdata);
        end
        n_vec++;
        if (cyc !== e.lat || pen !== e.pen) begin
          n_err++; $display("FAIL %s timing: latency=%0d access=%0d required latency=%0d access=%0d",
                            name, cyc, pen, e.lat, e.pen);
        end
        n_vec++;
        if (bad !== 1'b0) begin
          n_err++; $display("FAIL %s bus: unstable or wrong PSEL/PADDR/PWRITE/PSTRB/PPROT/PWDATA=1 required 0", name);
        end
        n_vec++;
        if (PSEL !== '0 || PENABLE !== 1'b0 || req_ready !== 1'b1) begin
          n_err++; $display("FAIL %s done: PSEL=%b PENABLE=%b ready=%b required 000 0 1",
                            name, PSEL, PENABLE, req_ready);
        end
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s rsp timeout: no rsp_valid within 64 cycles required one", name);
      void'(sb.pop_front());
      return;
    end
    @(negedge PCLK);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL %s pulse: rsp_valid=%b one cycle later required 0", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== '0 || PENABLE !== 1'b0 ||
        PADDR !== 32'h0 || PSTRB !== 4'h0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL reset: ready=%b rsp_valid=%b PSEL=%b PENABLE=%b PADDR=%h required 1 0 000 0 0",
                        req_ready, rsp_valid, PSEL, PENABLE, PADDR);
    end
    PRESETn = 1'b1;
  endtask

  task automatic test_write_slave1();
    rdata_cfg[1] = 32'hAAAA_5555;
    do_xfer("write_s1", 1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF, PPROT_PRIV,
            3'b010, 1'b0, 32'h0, 3, 1);
  endtask

  task automatic test_read_wait();
    wait_cfg[2] = 4; rdata_cfg[2] = 32'hDEAD_BEEF;
    do_xfer("read_wait_s2", 1'b0, 32'h8000_0000, 32'h0, 4'h0, PPROT_NSEC,
            3'b100, 1'b0, 32'hDEAD_BEEF, 7, 5);
    wait_cfg[2] = 0;
  endtask

  task automatic test_read_pstrb();
    rdata_cfg[0] = 32'h0BAD_F00D;
    do_xfer("read_pstrb_s0", 1'b0, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, PPROT_INSTR,
            3'b001, 1'b0, 32'h0BAD_F00D, 3, 1);
  endtask

  task automatic test_decode_err();
    do_xfer("decode_err", 1'b0, 32'hC000_0000, 32'h0, 4'h0, 3'b000,
            3'b000, 1'b1, 32'h0, 2, 0);
  endtask

  task automatic test_slverr();
    err_cfg[0] = 1'b1;
    do_xfer("slverr_s0", 1'b1, 32'h0000_0008, 32'hCAFE_0001, 4'h3, 3'b000,
            3'b001, 1'b1, 32'h0, 3, 1);
    err_cfg[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      int          s, w;
      logic        wr;
      logic [31:0] addr, wd;
      s  = k % NS;
      w  = int'($urandom_range(0, 2));
      wr = k[0];
      wd = $urandom;
      wait_cfg[s]  = w;
      rdata_cfg[s] = $urandom;
      addr = {2'(s), 30'($urandom_range(0, 255) * 4)};
      do_xfer("back_to_back", wr, addr, wd, 4'(k + 1), 3'(k), 3'(1 << s),
              1'b0, wr ? 32'h0 : rdata_cfg[s], 3 + w, 1 + w);
      wait_cfg[s] = 0;
    end
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  seen;
    wait_cfg[0] = 10;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; req_strb = 4'h0; req_prot = 3'b000;
    cyc = 0;
    while (!PENABLE && cyc < 10) begin @(negedge PCLK); cyc++; req_valid = 1'b0; end
    n_vec++;
    if (PENABLE !== 1'b1) begin
      n_err++; $display("FAIL reset_mid access: PENABLE=%b required 1", PENABLE);
    end
    PRESETn = 1'b0;
    @(negedge PCLK);
    n_vec++;
    if (PSEL !== '0 || PENABLE !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid drop: PSEL=%b PENABLE=%b ready=%b rsp_valid=%b required 000 0 1 0",
                        PSEL, PENABLE, req_ready, rsp_valid);
    end
    PRESETn = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge PCLK); if (rsp_valid || PSEL != '0) seen = 1; end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL reset_mid quiet: rsp or PSEL after reset=%b required 0", seen);
    end
    wait_cfg[0] = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    wait_cfg[1] = 1000;
    do_xfer("timeout_s1", 1'b0, 32'h4000_0000, 32'h0, 4'h0, 3'b000,
            3'b010, 1'b1, 32'h0, 18, 16);
    wait_cfg[1] = 0;
  endtask
`endif

  initial begin
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; err_cfg[i] = 1'b0; rdata_cfg[i] = 32'h5A5A_0000 + 32'(i);
    end
    test_reset();
    test_write_slave1();
    test_read_wait();
    test_read_pstrb();
    test_decode_err();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++; $display("FAIL scoreboard: %0d responses outstanding required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
